axil_mem_slave: RTL
===================

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_W words (power of 2, 2..1024).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h4000_0000, first byte address of the window.
REQ-005 SHALL have parameter B_LAT, default 1, cycles from write commit to bvalid (1..8).
REQ-006 SHALL have parameter R_LAT, default 1, cycles from AR handshake to rvalid (1..8).
REQ-007 SHALL have port clk, input, 1, clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have ports awaddr (input, ADDR_W), awvalid (input, 1) and awready (output, 1): write address channel.
REQ-010 SHALL have ports wdata (input, DATA_W), wstrb (input, DATA_W/8), wvalid (input, 1) and wready (output, 1): write data channel.
REQ-011 SHALL have ports bresp (output, 2), bvalid (output, 1) and bready (input, 1): write response channel.
REQ-012 SHALL have ports araddr (input, ADDR_W), arvalid (input, 1) and arready (output, 1): read address channel.
REQ-013 SHALL have ports rdata (output, DATA_W), rresp (output, 2), rvalid (output, 1) and rready (input, 1): read data channel.

Function
REQ-014 SHALL compute the word index as (addr - BASE_ADDR) >> log2(DATA_W/8), ignoring the low byte-offset bits; an address is in range iff addr >= BASE_ADDR and index < DEPTH.
REQ-015 SHALL run a write FSM with states W_IDLE, W_WAIT, W_RESP; awready and wready SHALL be low in W_WAIT and W_RESP, except that the channel not yet captured SHALL stay ready in W_IDLE.
REQ-016 SHALL accept AW and W independently, in any order or in the same cycle.
REQ-017 SHALL commit the write, byte-masked by wstrb, on the edge at which the later of the two handshakes completes; a same-cycle AW+W handshake SHALL commit on that edge.
REQ-018 SHALL enter W_WAIT at the commit edge and assert bvalid exactly B_LAT cycles after it.
REQ-019 SHALL hold bvalid and bresp stable until bready; W_RESP exits to W_IDLE on the bvalid&&bready edge; awready and wready SHALL reassert in the following cycle, never in the same cycle.
REQ-020 SHALL run a read FSM with states R_IDLE, R_WAIT, R_RESP; arready SHALL be high only in R_IDLE.
REQ-021 SHALL sample memory into rdata on the edge rvalid rises, R_LAT cycles after the AR handshake; a write committing on that same edge SHALL NOT be visible (old data returned).
REQ-022 SHALL hold rvalid, rdata and rresp stable until rready, then return to R_IDLE.
REQ-023 SHALL operate the read and write paths fully concurrently and independently.
REQ-024 SHALL return bresp and rresp of 2'b00 (OKAY) for in-range accesses.
REQ-025 SHALL ignore wstrb == 0 (no memory change) while still responding OKAY.

Reset
REQ-026 SHALL, while rst_n is low, hold awready, wready and arready at 1; hold bvalid and rvalid at 0; hold bresp, rresp and rdata at 0; clear all memory words to 0; and force both FSMs to their IDLE states.
REQ-027 SHALL abort any in-flight transaction when reset asserts mid-operation, with no response issued after release.

Configuration
REQ-028 SHALL, with AXIL_MEM_SLAVE_ERR_EN defined, respond 2'b10 (SLVERR) to out-of-range accesses, discard out-of-range writes, and return rdata 0 for out-of-range reads.
REQ-029 SHALL, without AXIL_MEM_SLAVE_ERR_EN, wrap out-of-range accesses onto index[log2(DEPTH)-1:0] and always respond OKAY.

Verification
REQ-030 SHALL cover: defaults; AW+W same cycle to 0x4000_0004 with data 0xDEADBEEF and wstrb 0xF -> bvalid one cycle after the commit, bresp 0; then read 0x4000_0004 -> rdata 0xDEADBEEF, rresp 0.
REQ-031 SHALL cover: W presented 3 cycles before AW at 0x4000_0008 -> wready low after the W handshake, single commit, single bvalid.
REQ-032 SHALL cover: wstrb 0x3 with data 0x1234_5678 over an existing 0xCAFEBABE -> readback 0xCAFE5678.
REQ-033 SHALL cover: B_LAT=4, R_LAT=3, bready held low 5 cycles -> bvalid rises 4 cycles after commit, stays stable, and awready stays low until the cycle after the bvalid&&bready handshake.
REQ-034 SHALL cover: with AXIL_MEM_SLAVE_ERR_EN, write 0x4000_0040 (DEPTH 16) -> bresp 2'b10 and memory unchanged; without the macro -> the same write aliases to word 0.
REQ-035 SHALL cover: rst_n pulsed low during W_WAIT -> bvalid stays 0 after release and all words read 0.

Source files
------------

// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite slave over a DEPTH-word flop memory with fixed B/R response latencies.
// Define AXIL_MEM_SLAVE_ERR_EN to answer SLVERR to out-of-window accesses instead of wrapping them.
module axil_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int                B_LAT     = 1,
    parameter int                R_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);
    localparam int SB = DATA_W / 8;
    localparam int SH = $clog2(SB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] aw_addr, ar_addr, c_addr;
    logic [DATA_W-1:0] w_data, c_data;
    logic [SB-1:0]     w_strb, c_strb;
    logic              aw_done, w_done, aw_fire, w_fire, ar_fire, commit, c_ok, r_ok;
    logic [2:0]        b_cnt, r_cnt;

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IW'((a - BASE_ADDR) >> SH);
    endfunction

`ifdef AXIL_MEM_SLAVE_ERR_EN
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return a >= BASE_ADDR && ((a - BASE_ADDR) >> SH) < ADDR_W'(DEPTH);
    endfunction
    assign c_ok = in_window(c_addr);
    assign r_ok = in_window(ar_addr);
`else
    assign c_ok = 1'b1;
    assign r_ok = 1'b1;
`endif

    // Each write channel stays ready in W_IDLE only until it has been captured.
    assign awready = w_state == W_IDLE && !aw_done;
    assign wready  = w_state == W_IDLE && !w_done;
    assign bvalid  = w_state == W_RESP;
    assign arready = r_state == R_IDLE;
    assign rvalid  = r_state == R_RESP;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign commit  = w_state == W_IDLE && (aw_fire || aw_done) && (w_fire || w_done);
    assign c_addr  = aw_done ? aw_addr : awaddr;
    assign c_data  = w_done ? w_data : wdata;
    assign c_strb  = w_done ? w_strb : wstrb;

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_IDLE:  w_next = commit ? W_WAIT : W_IDLE;
            W_WAIT:  w_next = b_cnt == 3'd0 ? W_RESP : W_WAIT;
            W_RESP:  w_next = bready ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE:  r_next = ar_fire ? R_WAIT : R_IDLE;
            R_WAIT:  r_next = r_cnt == 3'd0 ? R_RESP : R_WAIT;
            R_RESP:  r_next = rready ? R_IDLE : R_RESP;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            b_cnt   <= '0;
            r_cnt   <= '0;
            bresp   <= OKAY;
            rresp   <= OKAY;
            rdata   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            aw_done <= !commit && (aw_done || aw_fire);
            w_done  <= !commit && (w_done || w_fire);
            if (aw_fire) aw_addr <= awaddr;
            if (w_fire) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (commit) begin
                b_cnt <= 3'(B_LAT - 1);
                bresp <= c_ok ? OKAY : SLVERR;
                if (c_ok)
                    for (int b = 0; b < SB; b++)
                        if (c_strb[b]) mem[word_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
            end else if (w_state == W_WAIT) begin
                b_cnt <= b_cnt - 3'd1;
            end
            if (ar_fire) begin
                ar_addr <= araddr;
                r_cnt   <= 3'(R_LAT - 1);
            end else if (r_state == R_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Sampled with the pre-edge memory, so a write committing on this edge is not seen.
            if (r_state == R_WAIT && r_cnt == 3'd0) begin
                rdata <= r_ok ? mem[word_idx(ar_addr)] : '0;
                rresp <= r_ok ? OKAY : SLVERR;
            end
        end
    end
endmodule
